mux_stream_nto1: RTL and testbench
==================================

# mux_stream_nto1

Parametrised N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output, and a registered output stage. It is the sequential successor to the team's 4:1/8:1 combinational muxes. Channel count and data width are generic. Selection comes from an external select port, or, when compiled in, from a round-robin arbiter. It sits between several producer streams and a single consumer, for example a shared bus or a serialiser.

## Interface

- `N`, default 8: number of input channels, 2..64.
- `W`, default 8: data width per channel.
- `SW`, default $clog2(N): select/channel-index width. Derived; do not override.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  N  per-channel valid.
- `in_data`  in  N*W  channel k occupies bits [k*W +: W].
- `in_ready`  out  N  per-channel ready. At most one bit is high per cycle.
- `sel`  in  SW  channel select in fixed mode.
- `rr_mode`  in  1  1 = round-robin arbitration, 0 = fixed select. Ignored unless MUX_STREAM_RR_EN is defined.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered data.
- `out_ch`  out  SW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the beat.

## Operation

- **Single output register.** `load = !out_valid || out_ready`.
- **Grant `g`**, computed combinationally each cycle:
  - Fixed mode: `g = sel`, valid only when `sel < N` and `in_valid[sel]`.
  - Round-robin mode: the first k with `in_valid[k]` set, searching from `(ptr+1) mod N` upward and wrapping N-1→0. No grant if no input is valid.
- `in_ready[g] = load && grant_valid`. All other `in_ready` bits are 0. `in_ready` never depends on `in_valid` of other channels beyond the grant logic. `in_ready` is 0 while `rst` is high.
- **Transfer on channel g** when `in_valid[g] && in_ready[g]`. On the next edge: `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`. In round-robin mode, also `ptr <= g`.
- **Output fire without new load.** If `out_valid && out_ready` and there is no grant, `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- **Simultaneous drain and fill** in the same cycle: the new beat replaces the old one. Throughput is 1 beat/cycle.
- **Stall.** While `out_valid && !out_ready`, all `in_ready` are 0 and the output register is stable.
- **Out of range.** `sel >= N` (N not a power of 2) produces no grant and never reads out-of-range data.
- **Changing `sel` or `rr_mode`** takes effect on the next grant evaluation. A beat already registered is unaffected.
- **Reset values:** `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = N-1` (so the first round-robin search starts at channel 0).
- **Reset mid-operation** discards any held beat. No input transfer completes in a reset cycle.

## Timing

- Latency: input handshake at edge t, beat visible on `out_*` after edge t; `out_valid` is high in cycle t+1.
- All outputs are registered except `in_ready`. `in_ready` is combinational from `out_valid`, `out_ready`, `in_valid`, `sel`, `rr_mode` and `ptr`.
- No combinational path from `in_data` to any output.
- Round-robin fairness: with all N inputs continuously valid and `out_ready = 1`, each channel is granted exactly once per N consecutive beats.

## Configuration

- `MUX_STREAM_RR_EN`:
  - Defined: the round-robin pointer and arbiter are built, and `rr_mode` selects the mode.
  - Undefined: `ptr` and the arbiter are not synthesised, `rr_mode` is ignored, and the block always behaves in fixed-select mode.
  - The port list is identical in both builds.

## Test plan

- **Reset.** Assert `rst` 2 cycles with `in_valid = 8'hFF`. Required: `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `in_ready = 0` throughout; no beat appears after release until a handshake.
- **Fixed select, N=8, W=8.** `sel = 5`, `in_data[5] = 8'hA5`, `in_valid = 8'b0010_0000`, `out_ready = 1`. Required: `in_ready = 8'b0010_0000`; next cycle `out_valid = 1`, `out_data = 8'hA5`, `out_ch = 5`. Setting `sel = 3` with channel 3 idle gives `in_ready = 0`.
- **Backpressure.** Beat held, `out_ready = 0` for 4 cycles with new input valid. Required: `in_ready = 0`, `out_data` unchanged for all 4 cycles. Raising `out_ready` accepts the new beat in the same cycle (back-to-back, no bubble).
- **Round-robin** (macro defined, `rr_mode = 1`). `in_valid = 8'hFF`, `out_ready = 1` for 16 cycles. Required: `out_ch` sequence 0,1,…,7,0,…,7. Then `in_valid = 8'b1000_0001` after a grant to 7 → next grants 0, 7, 0.
- **Out-of-range select.** N=5, `sel = 6`, all valid. Required: `in_ready = 0`, `out_valid` stays 0.
- **Reset mid-stream.** Assert `rst` while `out_valid = 1` and `out_ready = 0`. Required: next cycle `out_valid = 0`; after release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1: N-to-1 valid/ready stream mux with a registered output stage.
// Defining MUX_STREAM_RR_EN builds the round-robin arbiter selected by rr_mode.
module mux_stream_nto1 #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  input  logic [SW-1:0]   sel,
  input  logic            rr_mode,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
);
  localparam logic [SW:0]   NL   = N[SW:0];
  localparam logic [SW-1:0] LAST = SW'(N - 1);
  logic          load, fix_gv, gv, fire;
  logic [SW-1:0] g;
  logic [W-1:0]  d;
  assign load   = !out_valid || out_ready;
  assign fix_gv = ({1'b0, sel} < NL) && |(in_valid & (N'(1) << sel));
`ifdef MUX_STREAM_RR_EN
  logic [SW-1:0] ptr, rr_g, idx;
  logic          rr_gv;
  // Scan downward so the last hit is the channel closest after ptr.
  always_comb begin
    rr_gv = 1'b0;
    rr_g  = '0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      idx = SW'((int'(ptr) + i) % N);
      if (in_valid[idx]) begin
        rr_gv = 1'b1;
        rr_g  = idx;
      end
    end
  end
  assign g  = rr_mode ? rr_g : sel;
  assign gv = rr_mode ? rr_gv : fix_gv;
  always_ff @(posedge clk)
    ptr <= rst ? LAST : (rr_mode && fire) ? g : ptr;
`else
  logic unused_rr;
  assign unused_rr = rr_mode;
  assign g  = sel;
  assign gv = fix_gv;
`endif
  assign fire     = !rst && load && gv;
  assign in_ready = fire ? N'(1) << g : '0;
  always_comb begin
    d = '0;
    for (int k = 0; k < N; k++)
      if (g == SW'(k)) d = in_data[k*W +: W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= d;
      out_ch    <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_stream_nto1.sv
// tb_mux_stream_nto1: vector table plus scoreboard bench for mux_stream_nto1 (N=8) and an N=5 out-of-range instance.
module tb_mux_stream_nto1;
`ifdef MUX_STREAM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_valid, in_ready, out_data;
  logic [63:0] in_data;
  logic [2:0]  sel, out_ch;
  logic        rr_mode, out_valid, out_ready;
  logic [4:0]  v5, rdy5;
  logic [39:0] d5;
  logic [2:0]  sel5, oc5;
  logic        ov5;
  logic [7:0]  od5;
  int          tests = 0;
  int          fails = 0;
  bit          m_valid = 1'b0;
  logic [7:0]  base = 8'hA0;
  logic [10:0] q[$];

  typedef struct {
    logic [7:0] v;
    logic [2:0] s;
    logic       r;
    logic [7:0] rdy;
    string      name;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  mux_stream_nto1 #(.N(8), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sel(sel), .rr_mode(rr_mode), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  mux_stream_nto1 #(.N(5), .W(8)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_ready(rdy5),
    .sel(sel5), .rr_mode(1'b0), .out_valid(ov5), .out_data(od5),
    .out_ch(oc5), .out_ready(1'b1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle from a negedge; expected beats enter the queue on handshake.
  task automatic step(input logic [7:0] v, input logic [2:0] s, input logic r,
                      input logic [7:0] exp_rdy, input string name);
    logic [2:0] gi;
    gi = '0;
    in_valid  = v;
    sel       = s;
    out_ready = r;
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = base + 8'(k);
    #1;
    chk({name, "_rdy"}, in_ready, exp_rdy);
    chk({name, "_ov"}, out_valid, m_valid);
    if (m_valid) begin
      if (q.size() == 0) chk({name, "_sb_empty"}, 1, 0);
      else begin
        chk({name, "_ch"}, out_ch, q[0][10:8]);
        chk({name, "_data"}, out_data, q[0][7:0]);
        if (r) void'(q.pop_front());
      end
    end
    if ((v & exp_rdy) != 8'h00) begin
      for (int k = 0; k < 8; k++) if (exp_rdy[k]) gi = 3'(k);
      q.push_back({gi, base + {5'b0, gi}});
      m_valid = 1'b1;
    end else if (r) m_valid = 1'b0;
    base = base + 8'h10;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{8'h20, 3'd5, 1'b1, 8'h20, "fix5"};
    tbl[1]  = '{8'h20, 3'd3, 1'b1, 8'h00, "idle3"};
    tbl[2]  = '{8'hFF, 3'd0, 1'b1, 8'h01, "sel0"};
    tbl[3]  = '{8'hFF, 3'd7, 1'b0, 8'h00, "stall7"};
    tbl[4]  = '{8'hFF, 3'd7, 1'b1, 8'h80, "fill7"};
    tbl[5]  = '{8'h7F, 3'd7, 1'b1, 8'h00, "no7"};
    tbl[6]  = '{8'h08, 3'd3, 1'b0, 8'h08, "empty_load"};
    tbl[7]  = '{8'h08, 3'd3, 1'b0, 8'h00, "stall3"};
    tbl[8]  = '{8'h08, 3'd3, 1'b1, 8'h08, "swap3"};
    tbl[9]  = '{8'h00, 3'd3, 1'b1, 8'h00, "drain"};
    tbl[10] = '{8'h02, 3'd1, 1'b1, 8'h02, "fix1"};

    rst = 1'b1; in_valid = 8'hFF; in_data = '0; sel = 3'd0; rr_mode = 1'b0; out_ready = 1'b1;
    v5 = 5'h1F; sel5 = 3'd6;
    for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'h50 + 8'(k);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk("rst_rdy", in_ready, 8'h00);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_data", out_data, 8'h00);
      chk("rst_ch", out_ch, 3'd0);
      chk("rst_rdy5", rdy5, 5'h00);
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 8'h00;
    #1 chk("oor_rdy", rdy5, 5'h00);
    @(negedge clk);
    step(8'h00, 3'd0, 1'b1, 8'h00, "post_rst_a");
    chk("oor_ov", ov5, 1'b0);
    chk("oor_rdy2", rdy5, 5'h00);
    sel5 = 3'd4;
    step(8'h00, 3'd0, 1'b1, 8'h00, "post_rst_b");
    chk("n5_rdy", rdy5, 5'h10);
    chk("n5_ov", ov5, 1'b1);
    chk("n5_ch", oc5, 3'd4);
    chk("n5_data", od5, 8'h54);

    for (int i = 0; i < 11; i++) step(tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].rdy, tbl[i].name);

    step(8'h04, 3'd2, 1'b1, 8'h04, "bp_load");
    for (int i = 0; i < 4; i++) step(8'h04, 3'd2, 1'b0, 8'h00, "bp_hold");
    step(8'h04, 3'd2, 1'b1, 8'h04, "bp_release");
    step(8'h00, 3'd2, 1'b1, 8'h00, "bp_drain");

`ifdef MUX_STREAM_RR_EN
    rr_mode = 1'b1;
    for (int i = 0; i < 16; i++) step(8'hFF, 3'd0, 1'b1, 8'h01 << (i % 8), "rr_seq");
    step(8'h81, 3'd0, 1'b1, 8'h01, "rr_wrap0");
    step(8'h81, 3'd0, 1'b1, 8'h80, "rr_alt7");
    step(8'h81, 3'd0, 1'b1, 8'h01, "rr_alt0");
    step(8'h00, 3'd0, 1'b1, 8'h00, "rr_drain");
`else
    rr_mode = 1'b1;
    step(8'hFF, 3'd3, 1'b1, 8'h08, "rr_ignored");
    step(8'h00, 3'd3, 1'b1, 8'h00, "rr_ign_drain");
`endif

    rr_mode = RR;
    step(8'hFF, 3'd1, 1'b1, 8'h02, "ms_load");
    step(8'hFF, 3'd1, 1'b0, 8'h00, "ms_stall");
    rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    #1 chk("ms_rst_rdy", in_ready, 8'h00);
    @(negedge clk);
    chk("ms_flush", out_valid, 1'b0);
    q.delete();
    m_valid = 1'b0;
    rst = 1'b0;
    step(8'hFF, 3'd1, 1'b1, RR ? 8'h01 : 8'h02, "ms_restart");
    step(8'h00, 3'd1, 1'b1, 8'h00, "ms_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
